// File: rtl/cycle_counter_rx_if.sv
// Byte stream from the UART receiver plus decoded count and status back to control logic.
// Latency: n/a (signal bundle only).
// Backpressure: none; uart_rx_valid is a strobe the receiver must always accept.
interface cycle_counter_rx_if;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic [15:0] cycle_count;
    logic        count_valid;
    logic        frame_error;
    logic [7:0]  error_count;
    logic        busy;

    // Byte source / result consumer side
    modport master (
        output uart_rx_valid,
        output uart_rx_data,
        input  cycle_count,
        input  count_valid,
        input  frame_error,
        input  error_count,
        input  busy
    );

    // Parser side
    modport slave (
        input  uart_rx_valid,
        input  uart_rx_data,
        output cycle_count,
        output count_valid,
        output frame_error,
        output error_count,
        output busy
    );
endinterface

// File: rtl/cycle_counter_rx.sv
// Parses "<DDD>" ASCII frames from the UART receiver into a binary cycle count.
// Latency: count_valid/frame_error pulse one cycle after the edge that sampled the deciding byte.
// Backpressure: none; every strobed byte is consumed in the cycle it arrives.
module cycle_counter_rx #(
    parameter int NUM_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    cycle_counter_rx_if.slave  bus
);
    localparam int              TW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      ND   = 3'(NUM_DIGITS);
    localparam logic [7:0]      LT   = 8'h3C;
    localparam logic [7:0]      GT   = 8'h3E;

    typedef enum logic [1:0] {IDLE, DIGITS, WAIT_GT} state_t;

    state_t        state, state_n;
    logic [15:0]   acc, acc_n;
    logic [2:0]    dcnt, dcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [15:0]   count_n;
    logic          valid_n;
    logic          err_n;

    logic is_digit;
    logic is_lt;
    logic is_gt;
    assign is_digit = (bus.uart_rx_data >= 8'h30) && (bus.uart_rx_data <= 8'h39);
    assign is_lt    = (bus.uart_rx_data == LT);
    assign is_gt    = (bus.uart_rx_data == GT);

    // Next-state and next-output decode; a '<' inside a frame restarts the frame after flagging it.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        dcnt_n  = dcnt;
        tcnt_n  = tcnt;
        count_n = bus.cycle_count;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.uart_rx_valid && is_lt) begin
                    state_n = DIGITS;
                    acc_n   = 16'd0;
                    dcnt_n  = 3'd0;
                    tcnt_n  = '0;
                end
            end
            DIGITS, WAIT_GT: begin
                if (bus.uart_rx_valid) begin
                    tcnt_n = '0;
                    if (is_lt) begin
                        err_n   = 1'b1;
                        state_n = DIGITS;
                        acc_n   = 16'd0;
                        dcnt_n  = 3'd0;
                    end else if (state == DIGITS && is_digit) begin
                        acc_n  = acc * 16'd10 + {12'd0, bus.uart_rx_data[3:0]};
                        dcnt_n = dcnt + 3'd1;
                        if (dcnt + 3'd1 == ND) begin
                            state_n = WAIT_GT;
                        end
                    end else if (state == WAIT_GT && is_gt) begin
                        count_n = acc;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tcnt == TMAX) begin
                    // Stalled frame: abandon it; a byte on this same cycle is handled above instead.
                    err_n   = 1'b1;
                    state_n = IDLE;
                    tcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; error counter saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            acc             <= 16'd0;
            dcnt            <= 3'd0;
            tcnt            <= '0;
            bus.cycle_count <= 16'd0;
            bus.count_valid <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.error_count <= 8'd0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_n;
            acc             <= acc_n;
            dcnt            <= dcnt_n;
            tcnt            <= tcnt_n;
            bus.cycle_count <= count_n;
            bus.count_valid <= valid_n;
            bus.frame_error <= err_n;
            bus.busy        <= (state_n != IDLE);
            if (err_n && bus.error_count != 8'hFF) begin
                bus.error_count <= bus.error_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_cycle_counter_rx.sv
// Scoreboard bench for cycle_counter_rx: expected pulses are queued as bytes are sent,
// a negedge monitor pops and compares every count_valid / frame_error pulse.
module tb_cycle_counter_rx;
    logic clk;
    logic rst;

    cycle_counter_rx_if bus ();

    cycle_counter_rx #(
        .NUM_DIGITS     (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        kind;   // 0: count_valid, 1: frame_error
        logic [15:0] val;    // cycle_count, or error_count for errors
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  exp_errs = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_valid(input int v);
        ev_t e;
        e.kind = 1'b0;
        e.val  = 16'(v);
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        if (exp_errs < 255) exp_errs++;
        e.kind = 1'b1;
        e.val  = 16'(exp_errs);
        exp_q.push_back(e);
    endtask

    // Caller is positioned just after a rising edge; returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = b;
        @(posedge clk); #1;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'h00;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1);
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.count_valid && bus.frame_error) begin
            n_cmp++;
            n_err++;
            $display("FAIL both_pulses: count_valid and frame_error high together");
        end else if (bus.count_valid || bus.frame_error) begin
            ev_t e;
            ev_t g;
            g.kind = bus.frame_error;
            g.val  = bus.frame_error ? {8'h00, bus.error_count} : bus.cycle_count;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got kind=%0d val=%0d, expected no pulse",
                         g.kind, g.val);
            end else begin
                e = exp_q.pop_front();
                if (e != g) begin
                    n_err++;
                    $display("FAIL pulse: got kind=%0d val=%0d, expected kind=%0d val=%0d",
                             g.kind, g.val, e.kind, e.val);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        check("rst_cycle_count", int'(bus.cycle_count), 0);
        check("rst_count_valid", int'(bus.count_valid), 0);
        check("rst_frame_error", int'(bus.frame_error), 0);
        check("rst_error_count", int'(bus.error_count), 0);
        check("rst_busy",        int'(bus.busy),        0);

        // 1: basic frame; busy tracks the frame
        push_valid(42);
        send_byte("<", 0);
        check("t1_busy_mid", int'(bus.busy), 1);
        @(posedge clk); #1;
        send_str("042");
        send_byte(">", 0);
        check("t1_busy_after", int'(bus.busy), 0);
        send_str("\r\n");
        check("t1_cycle_count", int'(bus.cycle_count), 42);

        // 2: extremes, count holds between frames
        push_valid(999);
        push_valid(0);
        send_str("<999>\r\n<000>\r\n");
        repeat (5) @(posedge clk);
        #1;
        check("t2_hold", int'(bus.cycle_count), 0);

        // 3: bad digit; trailing '2>' falls into IDLE and is ignored
        push_err();
        send_str("<4A2>\r\n");
        check("t3_error_count", int'(bus.error_count), 1);
        check("t3_unchanged",   int'(bus.cycle_count), 0);
        push_valid(123);
        send_str("<123>\r\n");

        // 4: resync on '<' inside a frame
        push_err();
        push_valid(345);
        send_str("<12<345>\r\n");
        check("t4_error_count", int'(bus.error_count), 2);

        // 5: timeout after 16 silent cycles, then stray bytes ignored
        push_err();
        send_str("<1");
        send_byte("2", 0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.frame_error && n == 0) n = k;
        end
        check("t5_timeout_cycle", n, 16);
        check("t5_busy", int'(bus.busy), 0);
        send_str("5>");
        check("t5_cycle_count", int'(bus.cycle_count), 345);
        check("t5_error_count", int'(bus.error_count), 3);

        // 6: saturation of error_count
        for (int i = 0; i < 300; i++) begin
            push_err();
            send_str("<x");
        end
        check("t6_saturated", int'(bus.error_count), 255);

        // Reset mid-frame: no error pulse, everything back to zero
        send_str("<12");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_cycle_count", int'(bus.cycle_count), 0);
        check("t6_rst_error_count", int'(bus.error_count), 0);
        check("t6_rst_busy",        int'(bus.busy),        0);
        check("t6_rst_frame_error", int'(bus.frame_error), 0);
        exp_errs = 0;
        push_valid(7);
        send_str("<007>\r\n");
        check("t6_final_count", int'(bus.cycle_count), 7);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
